sprite_blit_scheduler: RTL
==========================

// Module: sprite_blit_scheduler
// PURPOSE
//  Shares the SRAM controller's program-write port between NUM_REQ sprite clients (player, zombies, bullets).
//  Round-robin arbitration picks one client per blit. The block scans that client's SPR_W x SPR_H sprite
//  from the sprite ROM. Each visible, on-screen pixel becomes one program write into the hidden frame,
//  issued only in the controller's write slots. Sits between game logic and the SRAM controller on sram_clk.
// PARAMETERS
//  NUM_REQ      4        number of requesting clients (2..8)
//  SPR_W        32       sprite width in pixels (power of 2)
//  SPR_H        32       sprite height in pixels (power of 2)
//  SPR_ID_W     4        sprite index width; rom_addr = {id, row, col}
//  TRANSPARENT  16'hF81F colour key; pixels equal to it are skipped
//  SCREEN_W     640      visible width; SCREEN_H 480 visible height
// PORTS
//  sram_clk      in   1                    100 MHz clock
//  reset         in   1                    asynchronous, active-high reset
//  frame_start   in   1                    1-cycle pulse, synced frame_clk rising edge
//  req           in   NUM_REQ              level request per client; held until done[i]
//  req_x         in   NUM_REQ*10           sprite top-left X per client
//  req_y         in   NUM_REQ*10           sprite top-left Y per client
//  req_sprite    in   NUM_REQ*SPR_ID_W     sprite index per client
//  done          out  NUM_REQ              1-cycle pulse, blit of client i complete
//  rom_addr      out  SPR_ID_W+log2(SPR_W*SPR_H)  sprite ROM address
//  rom_data      in   16                   ROM pixel, valid 1 cycle after rom_addr
//  write_slot    in   1                    high in the cycle the controller latches program_* (WRITE stages)
//  program_x     out  10                   pixel X
//  program_y     out  10                   pixel Y
//  program_data  out  16                   pixel colour
//  program_we    out  1                    program_* valid; write happens when program_we & write_slot
//  busy          out  1                    high outside IDLE
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, rr_ptr 0, row/col counters 0.
//  FSM states: IDLE, ADDR, DATA, WRITE, NEXT.
//   IDLE:  if any req, grant the first requester at or after rr_ptr (circular). Latch its x/y/id.
//          Clear row/col. Go to ADDR.
//   ADDR:  drive rom_addr = {id,row,col}. Go to DATA.
//   DATA:  rom_data valid; compute px = x+col, py = y+row as 11-bit sums.
//          Pixel is visible iff rom_data != TRANSPARENT && px < SCREEN_W && py < SCREEN_H.
//          If visible: register program_x/y/data = px[9:0]/py[9:0]/rom_data, set program_we, go to WRITE.
//          Otherwise go to NEXT.
//   WRITE: hold program_*; when write_slot=1, clear program_we next cycle and go to NEXT.
//   NEXT:  col++; at col wrap, row++. After the last pixel (row=SPR_H-1, col=SPR_W-1):
//          pulse done[g] for one cycle, set rr_ptr = g+1 mod NUM_REQ, go to IDLE. Else go to ADDR.
//  Latency: skipped pixel 3 cycles. Written pixel 3 cycles + wait for write_slot (<=2 cycles at the 1-in-2 slot rate).
//  Overflow: coordinates use an 11-bit sum, so px >= 1024 wrap is impossible; offscreen pixels are clipped, never wrapped.
//  frame_start has priority over every state: abort the blit, program_we=0, no done pulse, go to IDLE.
//   rr_ptr is kept. The aborted client restarts next frame if it still requests.
//  req[g] dropped mid-blit: ignored. The blit completes and done still pulses.
//  done and a new grant never share a cycle; IDLE always takes 1 cycle.
//  program_* change only in DATA->WRITE; they are stable while program_we=1.
//  Reset mid-blit: immediate return to the reset values above.
// STRUCTURE
//  Shared package boxhead_pkg: SCREEN_W/SCREEN_H constants, TRANSPARENT colour, blit_state_e enum.
//  Sub-module rr_arbiter (NUM_REQ): inputs req and rr_ptr, outputs one-hot grant and index. Purely combinational.
//  Counters, address calculation and the FSM live in this module.
// TESTING
//  1 Single client 0 at (100,50), opaque sprite, write_slot every 2nd cycle -> 1024 writes.
//    Coordinates (100..131, 50..81) in raster order; done[0] pulses once.
//  2 Clients 0,2,3 request together, rr_ptr=0 -> blit order 0,2,3.
//    Re-request all -> order 0,2,3 again. rr_ptr after the last grant = 0.
//  3 Sprite all TRANSPARENT except pixel (5,7) -> exactly one write at (x+5,y+7).
//    Blit takes 1024*3 + write-wait cycles.
//  4 Client at (630,470) -> only 10x10 = 100 writes; no program_x>=640 or program_y>=480 ever seen.
//  5 frame_start in mid-blit, in WRITE state with write_slot=0 -> program_we drops next cycle.
//    No done pulse; IDLE next cycle; same client regranted.
//  6 Assert reset while program_we=1 -> all outputs 0 asynchronously; after release, IDLE with rr_ptr=0.

Source files
------------

// File: rtl/boxhead_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boxhead_pkg
// Brief    : Screen geometry, colour key and blitter state encoding.
// Revision : 1.0
// ============================================================================
package boxhead_pkg;

  localparam logic [10:0] SCREEN_W_PX     = 11'd640;
  localparam logic [10:0] SCREEN_H_PX     = 11'd480;
  localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4
  } blit_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first requester at or after rr_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= NREQ_L) cand = cand - NREQ_L;
      if (req[cand[IDX_W-1:0]]) begin
        grant                   = '0;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
        grant_valid             = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blit_scheduler
// Brief    : Round-robin sprite blitter feeding the SRAM controller program-write port.
// Revision : 1.0
// ============================================================================
module sprite_blit_scheduler
  import boxhead_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter int          SPR_ID_W    = 4,
  parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY,
  parameter logic [10:0] SCREEN_W    = SCREEN_W_PX,
  parameter logic [10:0] SCREEN_H    = SCREEN_H_PX,
  localparam int         COL_W       = $clog2(SPR_W),
  localparam int         ROW_W       = $clog2(SPR_H),
  localparam int         ADDR_W      = SPR_ID_W + ROW_W + COL_W,
  localparam int         IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                         sram_clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*10-1:0]        req_x,
  input  logic [NUM_REQ*10-1:0]        req_y,
  input  logic [NUM_REQ*SPR_ID_W-1:0]  req_sprite,
  output logic [NUM_REQ-1:0]           done,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [15:0]                  rom_data,
  input  logic                         write_slot,
  output logic [9:0]                   program_x,
  output logic [9:0]                   program_y,
  output logic [15:0]                  program_data,
  output logic                         program_we,
  output logic                         busy
);

  blit_state_e          state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [9:0]           x_q, x_d, y_q, y_d;
  logic [SPR_ID_W-1:0]  id_q, id_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [9:0]           px_q, px_d, py_q, py_d;
  logic [15:0]          pdata_q, pdata_d;
  logic                 we_q, we_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [10:0]          px_sum, py_sum;
  logic                 visible, last_pix;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // 11-bit sums keep offscreen pixels from wrapping back onto the screen.
  assign px_sum   = {1'b0, x_q} + 11'(col_q);
  assign py_sum   = {1'b0, y_q} + 11'(row_q);
  assign visible  = (rom_data != TRANSPARENT) && (px_sum < SCREEN_W) && (py_sum < SCREEN_H);
  assign last_pix = (&row_q) && (&col_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    x_d      = x_q;
    y_d      = y_q;
    id_d     = id_q;
    row_d    = row_q;
    col_d    = col_q;
    done_d   = '0;
    px_d     = px_q;
    py_d     = py_q;
    pdata_d  = pdata_q;
    we_d     = we_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gidx_d  = arb_idx;
          gnt_d   = arb_grant;
          x_d     = req_x[int'(arb_idx)*10 +: 10];
          y_d     = req_y[int'(arb_idx)*10 +: 10];
          id_d    = req_sprite[int'(arb_idx)*SPR_ID_W +: SPR_ID_W];
          row_d   = '0;
          col_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (visible) begin
          px_d    = px_sum[9:0];
          py_d    = py_sum[9:0];
          pdata_d = rom_data;
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          done_d  = last_pix ? gnt_q : '0;
          state_d = ST_NEXT;
        end
      end
      ST_WRITE: begin
        if (write_slot) begin
          we_d    = 1'b0;
          done_d  = last_pix ? gnt_q : '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_pix) begin
          rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          state_d  = ST_IDLE;
        end else begin
          col_d = col_q + COL_W'(1);
          if (&col_q) row_d = row_q + ROW_W'(1);
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame abandons the blit without completing it; fairness pointer is untouched.
    if (frame_start) begin
      state_d  = ST_IDLE;
      we_d     = 1'b0;
      done_d   = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge sram_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      id_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      done_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      pdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      id_q     <= id_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pdata_q  <= pdata_d;
      we_q     <= we_d;
    end
  end

  assign done         = done_q;
  assign rom_addr     = {id_q, row_q, col_q};
  assign program_x    = px_q;
  assign program_y    = py_q;
  assign program_data = pdata_q;
  assign program_we   = we_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
